spi_peripheral: RTL
===================

Name: spi_peripheral

Overview:
- SPI target (slave) endpoint: the responder side of the bus driven by spi_controller.
- Receives SCLK, CS_n and MOSI from an external SPI master, oversampled on the system clock. Returns MISO data.
- Presents received bytes on a valid/ready stream backed by a small RX FIFO, and accepts transmit bytes through a one-deep holding register.
- Serves as an on-chip SPI responder for system-level loopback/verification and for MCU-attached peripheral modes.

Parameters:
DATA_WIDTH, 8, bits per SPI word; MSB first.
RX_DEPTH, 4, RX FIFO entries; power of two, ≥2.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sclk  in  1  SPI clock from master, asynchronous to clk
cs_n  in  1  SPI chip select, active-low, asynchronous
mosi  in  1  master-out serial data, asynchronous
miso  out  1  master-in serial data
miso_oe  out  1  MISO drive enable, for an external tristate
rx_data  out  DATA_WIDTH  head of RX FIFO
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  consumer pops the head when rx_valid && rx_ready
tx_data  in  DATA_WIDTH  next word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty; load when tx_valid && tx_ready
busy  out  1  frame in progress (synchronised cs_n low and armed)
rx_overflow  out  1  1-cycle pulse: received word dropped, FIFO full
tx_underrun  out  1  1-cycle pulse: word slot started with holding register empty
frame_abort  out  1  1-cycle pulse: CS_n deasserted mid-word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: miso=0, miso_oe=0, rx_valid=0, rx_data=0, tx_ready=1, busy=0, all pulses 0. Reset also clears the FIFO, the holding register, bit_cnt and the armed flag.
- Synchronisation:
  - sclk, cs_n and mosi each pass through a 2-FF synchroniser.
  - SCLK rise/fall are detected from the synced value versus its previous registered value.
  - Timing requirement: SCLK high and low phases must each be ≥3 clk periods.
  - Mode 0 only (CPOL=0, CPHA=0).
- Arming:
  - After reset the block is disarmed. It ignores SCLK until synced cs_n has been seen high; then armed=1.
  - Consequence: a frame already in progress at reset release is ignored entirely.
- Frame start (synced cs_n falling while armed):
  - busy=1, miso_oe=1, bit_cnt=0.
  - Load tx_shift from the holding register and free it. If the holding register is empty, load 0 and pulse tx_underrun.
  - miso = tx_shift MSB.
- SCLK rising (busy):
  - rx_shift <= {rx_shift, mosi}; bit_cnt++.
  - When bit_cnt was DATA_WIDTH-1: push the completed word, bit_cnt=0, set reload_pending.
- SCLK falling (busy):
  - If reload_pending: load tx_shift from the holding register (underrun rule as at frame start) and clear reload_pending.
  - Else: tx_shift <<= 1.
  - miso always follows tx_shift MSB.
- Frame end (synced cs_n rising):
  - busy=0, miso_oe=0, miso=0.
  - If bit_cnt≠0: pulse frame_abort and discard the partial RX word.
  - A TX word already loaded into tx_shift counts as consumed; the holding register is not restored.
  - bit_cnt and reload_pending cleared.
- Latency: a word appears on rx_valid ≤4 clk after the final SCLK rising edge at the pin.
- RX FIFO:
  - First-word fall-through: rx_data is valid whenever rx_valid=1.
  - Push while full with no pop in the same cycle: word dropped, rx_overflow pulses, contents unchanged.
  - Push and pop in the same cycle while full: both performed.
  - Pointers wrap modulo RX_DEPTH.
- TX holding register:
  - tx_ready = ~hold_full.
  - A load and a shift-register fetch in the same cycle: the fetch takes the old content and the new word is written, so hold_full stays 1.
- Words are back-to-back within a single CS assertion with no gap; bit_cnt keeps word alignment.

Test Plan:
- Reset asserted 3 cycles -> miso=0, miso_oe=0, rx_valid=0, tx_ready=1, busy=0; SCLK toggles during an active frame at reset release produce no rx_valid.
- Load tx 0xA5; master sends 0x3C in one mode-0 frame -> master captures 0xA5; rx_valid with rx_data=0x3C exactly once; tx_ready back to 1.
- Load 0x11, then 0x22 while the first word shifts; master clocks 3 words 0x01,0x02,0x03 in one CS -> master receives 0x11,0x22,0x00; tx_underrun pulses once; RX pops 0x01,0x02,0x03.
- rx_ready=0; master sends 0x01..0x05 -> rx_overflow pulses once on the 5th word; pops yield 0x01..0x04, then rx_valid=0.
- CS_n deasserted after 5 SCLK edges, then a new frame sends 0x7E -> frame_abort pulses once, no word pushed from the aborted frame, next rx_data=0x7E.
- Stream 255 words 0x00..0xFE with rx_ready=1 and tx refilled each word with the same values -> every byte received in order both directions, no pulse flags.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI target endpoint, mode 0 only. SCLK, CS_n and MOSI are oversampled on clk
// through 2-FF synchronisers. Received words are queued in a small
// first-word-fall-through RX FIFO. Transmit words come from a one-deep holding
// register that refills the shift register at each word boundary.
`timescale 1ns/1ps
module spi_peripheral #(
   parameter int DATA_WIDTH = 8,
   parameter int RX_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  rx_overflow,
   output logic                  tx_underrun,
   output logic                  frame_abort
);

   localparam int CNT_W   = $clog2(DATA_WIDTH);
   localparam int PTR_W   = $clog2(RX_DEPTH);
   localparam int FILL_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_ARMED    = 2'd1,
      S_BUSY     = 2'd2
   } state_t;

   state_t state, state_nxt;

   // synchroniser stages: _p0/_p1 are the 2-FF chain, _p2 is the previous synced value
   logic sclk_p0, sclk_p1, sclk_p2;
   logic cs_n_p0, cs_n_p1, cs_n_p2;
   logic mosi_p0, mosi_p1;

   logic sclk_rise, sclk_fall, cs_fall;
   logic frame_start, frame_end, bit_rise, bit_fall;

   logic [CNT_W-1:0]      bit_cnt;
   logic                  reload_pending;
   logic [DATA_WIDTH-2:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic                  word_done, fetch, hold_load;

   logic [DATA_WIDTH-1:0] mem [RX_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [FILL_W-1:0]     fill;
   logic                  fifo_full, push_ok, pop;

   // Bring the asynchronous SPI pins into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_n_p0 <= 1'b0;
         cs_n_p1 <= 1'b0;
         cs_n_p2 <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         sclk_p0 <= sclk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_n_p0 <= cs_n;
         cs_n_p1 <= cs_n_p0;
         cs_n_p2 <= cs_n_p1;
         mosi_p0 <= mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   assign sclk_rise = sclk_p1 & ~sclk_p2;
   assign sclk_fall = ~sclk_p1 & sclk_p2;
   assign cs_fall   = ~cs_n_p1 & cs_n_p2;

   // Frame state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_DISARMED;
      else     state <= state_nxt;
   end

   // Arming and frame sequencing; CS_n release has priority over any SCLK edge
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      bit_rise    = 1'b0;
      bit_fall    = 1'b0;
      case (state)
         S_DISARMED: if (cs_n_p1) state_nxt = S_ARMED;
         S_ARMED: begin
            if (cs_fall) begin
               state_nxt   = S_BUSY;
               frame_start = 1'b1;
            end
         end
         S_BUSY: begin
            if (cs_n_p1) begin
               state_nxt = S_ARMED;
               frame_end = 1'b1;
            end else begin
               bit_rise = sclk_rise;
               bit_fall = sclk_fall;
            end
         end
         default: state_nxt = S_DISARMED;
      endcase
   end

   assign word_done = bit_rise && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign rx_word   = {rx_shift, mosi_p1};
   assign fetch     = frame_start | (bit_fall & reload_pending);
   assign hold_load = tx_valid & ~hold_full;

   assign fifo_full = (fill == FILL_W'(RX_DEPTH));
   assign rx_valid  = (fill != '0);
   assign pop       = rx_valid & rx_ready;
   assign push_ok   = word_done & (~fifo_full | pop);

   // Control state: bit counter, reload flag, holding-register flag, FIFO pointers, pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt        <= '0;
         reload_pending <= 1'b0;
         hold_full      <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fill           <= '0;
         rx_overflow    <= 1'b0;
         tx_underrun    <= 1'b0;
         frame_abort    <= 1'b0;
      end else begin
         if (frame_start || frame_end) bit_cnt <= '0;
         else if (bit_rise)            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);

         if (frame_start || frame_end)         reload_pending <= 1'b0;
         else if (word_done)                   reload_pending <= 1'b1;
         else if (bit_fall && reload_pending)  reload_pending <= 1'b0;

         // a fetch and a load in the same cycle leave the new word in the register
         if (hold_load)  hold_full <= 1'b1;
         else if (fetch) hold_full <= 1'b0;

         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase

         rx_overflow <= word_done & fifo_full & ~pop;
         tx_underrun <= fetch & ~hold_full;
         frame_abort <= frame_end & (bit_cnt != '0);
      end
   end

   // Data path: shift registers, holding register and FIFO storage
   always_ff @(posedge clk) begin
      if (bit_rise)  rx_shift  <= rx_word[DATA_WIDTH-2:0];
      if (hold_load) hold_data <= tx_data;
      if (fetch)         tx_shift <= hold_full ? hold_data : '0;
      else if (bit_fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (push_ok) mem[wr_ptr] <= rx_word;
   end

   assign busy     = (state == S_BUSY);
   assign miso_oe  = busy;
   assign miso     = busy & tx_shift[DATA_WIDTH-1];
   assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
   assign tx_ready = ~hold_full;

endmodule
